enemy_grid_draw: RTL

//  Downstream consumer of the enemy position generator. Takes the formation base

---
 rtl/enemy_grid_draw.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/enemy_grid_draw.sv
// ---------------------------------------------------------------------------
// enemy_grid_draw
//
// Purpose:
//   Draws a ROWS x COLS formation of enemy boxes into the VGA pixel stream.
//   The formation's top-left corner follows (x_base, y_base) from the enemy
//   position generator. Each enemy has an alive bit. A live enemy whose box
//   contains the player missile tip is killed. When every enemy is dead the
//   level-clear flag (all_dead) is raised for the game controller. Any change
//   of the level input brings the whole formation back.
//
// Ports:
//   pclk, rst            pixel clock, synchronous active-high reset
//   level                current level; a change re-arms all enemies
//   x_base, y_base       formation top-left corner in pixels
//   hcount_in..rgb_in    upstream VGA timing and pixel colour
//   missile_x/y/vld      missile tip position and its valid qualifier
//   hcount_out..vblnk_out  VGA timing, delayed by exactly 2 cycles
//   rgb_out              composed pixel, 2-cycle latency, 0 while blanking
//   hit, kill_idx        one-cycle kill pulse and the killed enemy's index
//   alive                alive mask, bit row*COLS+col; unused bits read 0
//   all_dead             high while no enemy is alive (1 cycle behind alive)
// ---------------------------------------------------------------------------
module enemy_grid_draw #(
    parameter int          COLS       = 8,
    parameter int          ROWS       = 3,
    parameter int          SLOT_SHIFT = 6,
    parameter int          ROW_SHIFT  = 6,
    parameter int          ENEMY_W    = 40,
    parameter int          ENEMY_H    = 32,
    parameter logic [11:0] ENEMY_RGB  = 12'hF00
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [3:0]  level,
    input  logic [10:0] x_base,
    input  logic [10:0] y_base,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [10:0] missile_x,
    input  logic [10:0] missile_y,
    input  logic        missile_vld,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        hit,
    output logic [4:0]  kill_idx,
    output logic [31:0] alive,
    output logic        all_dead
);

    localparam int          NUM       = COLS * ROWS;
    localparam logic [31:0] ALL_MASK  = (NUM >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << NUM) - 32'd1);
    localparam logic [10:0] COLS_L    = 11'(COLS);
    localparam logic [10:0] ROWS_L    = 11'(ROWS);
    localparam logic [10:0] EW_L      = 11'(ENEMY_W);
    localparam logic [10:0] EH_L      = 11'(ENEMY_H);
    localparam logic [10:0] XOFF_MASK = 11'((1 << SLOT_SHIFT) - 1);
    localparam logic [10:0] YOFF_MASK = 11'((1 << ROW_SHIFT) - 1);

    typedef struct packed {
        logic       in_box;
        logic [4:0] idx;
    } box_t;

    // Maps a screen point onto the grid. The subtraction is done one bit wider
    // so that a point left of / above the formation shows up as a set sign bit
    // instead of wrapping into a far-right slot.
    function automatic box_t locate(input logic [10:0] px, input logic [10:0] py,
                                    input logic [10:0] bx, input logic [10:0] by);
        logic [11:0] rx;
        logic [11:0] ry;
        logic [10:0] col;
        logic [10:0] row;
        logic [10:0] lin;
        box_t        r;
        rx  = {1'b0, px} - {1'b0, bx};
        ry  = {1'b0, py} - {1'b0, by};
        col = rx[10:0] >> SLOT_SHIFT;
        row = ry[10:0] >> ROW_SHIFT;
        lin = row * COLS_L + col;
        r.in_box = !rx[11] && !ry[11] && (col < COLS_L) && (row < ROWS_L)
                   && ((rx[10:0] & XOFF_MASK) < EW_L)
                   && ((ry[10:0] & YOFF_MASK) < EH_L);
        r.idx    = lin[4:0];
        return r;
    endfunction

    // Stage 1 registers
    logic        in_box_q;
    logic [4:0]  idx_q;
    logic [10:0] hcount1_q, vcount1_q;
    logic        hsync1_q, vsync1_q, hblnk1_q, vblnk1_q;
    logic [11:0] rgb1_q;

    // Stage 2 registers
    logic [10:0] hcount2_q, vcount2_q;
    logic        hsync2_q, vsync2_q, hblnk2_q, vblnk2_q;
    logic [11:0] rgb2_q;

    // Enemy state
    logic [31:0] alive_q, alive_d;
    logic        hit_q, hit_d;
    logic [4:0]  kill_idx_q, kill_idx_d;
    logic [3:0]  level_q, level_d;
    logic        all_dead_q;

    box_t pix_box;
    box_t mis_box;
    logic [11:0] rgb2_d;

    assign pix_box = locate(hcount_in, vcount_in, x_base, y_base);
    assign mis_box = locate(missile_x, missile_y, x_base, y_base);

    // Alive is sampled at the second stage so a kill takes effect on the very
    // next pixel drawn rather than one frame later.
    always_comb begin
        rgb2_d = rgb1_q;
        if (hblnk1_q || vblnk1_q) begin
            rgb2_d = 12'h000;
        end else if (in_box_q && alive_q[idx_q]) begin
            rgb2_d = ENEMY_RGB;
        end
    end

    // Re-arm wins over a kill in the same cycle; otherwise at most one kill.
    always_comb begin
        alive_d    = alive_q;
        hit_d      = 1'b0;
        kill_idx_d = kill_idx_q;
        level_d    = level_q;
        if (level != level_q) begin
            alive_d = ALL_MASK;
            level_d = level;
        end else if (missile_vld && mis_box.in_box && alive_q[mis_box.idx]) begin
            alive_d[mis_box.idx] = 1'b0;
            hit_d                = 1'b1;
            kill_idx_d           = mis_box.idx;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            in_box_q   <= 1'b0;
            idx_q      <= 5'd0;
            hcount1_q  <= 11'd0;
            vcount1_q  <= 11'd0;
            hsync1_q   <= 1'b0;
            vsync1_q   <= 1'b0;
            hblnk1_q   <= 1'b0;
            vblnk1_q   <= 1'b0;
            rgb1_q     <= 12'h000;
            hcount2_q  <= 11'd0;
            vcount2_q  <= 11'd0;
            hsync2_q   <= 1'b0;
            vsync2_q   <= 1'b0;
            hblnk2_q   <= 1'b0;
            vblnk2_q   <= 1'b0;
            rgb2_q     <= 12'h000;
            alive_q    <= ALL_MASK;
            hit_q      <= 1'b0;
            kill_idx_q <= 5'd0;
            level_q    <= level;
            all_dead_q <= 1'b0;
        end else begin
            // Stage 1: grid lookup of the current pixel
            in_box_q   <= pix_box.in_box;
            idx_q      <= pix_box.idx;
            hcount1_q  <= hcount_in;
            vcount1_q  <= vcount_in;
            hsync1_q   <= hsync_in;
            vsync1_q   <= vsync_in;
            hblnk1_q   <= hblnk_in;
            vblnk1_q   <= vblnk_in;
            rgb1_q     <= rgb_in;
            // Stage 2: colour composition
            hcount2_q  <= hcount1_q;
            vcount2_q  <= vcount1_q;
            hsync2_q   <= hsync1_q;
            vsync2_q   <= vsync1_q;
            hblnk2_q   <= hblnk1_q;
            vblnk2_q   <= vblnk1_q;
            rgb2_q     <= rgb2_d;
            // Enemy state
            alive_q    <= alive_d;
            hit_q      <= hit_d;
            kill_idx_q <= kill_idx_d;
            level_q    <= level_d;
            all_dead_q <= (alive_q == 32'd0);
        end
    end

    assign hcount_out = hcount2_q;
    assign vcount_out = vcount2_q;
    assign hsync_out  = hsync2_q;
    assign vsync_out  = vsync2_q;
    assign hblnk_out  = hblnk2_q;
    assign vblnk_out  = vblnk2_q;
    assign rgb_out    = rgb2_q;
    assign hit        = hit_q;
    assign kill_idx   = kill_idx_q;
    assign alive      = alive_q;
    assign all_dead   = all_dead_q;

endmodule
